pkt_transmit: RTL and testbench

PKT_TRANSMIT -- requirements
Module: pkt_transmit

---
 rtl/pkt_transmit_pkg.sv | 32 +++
 rtl/pkt_transmit_fifo_sync.sv | 53 +++++
 rtl/pkt_transmit.sv | 183 ++++++++++++++++++
 tb/tb_pkt_transmit.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_transmit_pkg.sv
// Shared UM constants for the transmit block: word flag codes, widths,
// FIFO depths, FSM state type and small word helpers.
package pkt_transmit_pkg;

   localparam int WIDTH_PKT       = 139;
   localparam int WIDTH_META      = 288;
   localparam int PKT_FIFO_DEPTH  = 256;
   localparam int FLAG_FIFO_DEPTH = 16;

   localparam logic [2:0] FLAG_HEAD = 3'b101;
   localparam logic [2:0] FLAG_BODY = 3'b100;
   localparam logic [2:0] FLAG_TAIL = 3'b110;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      DISCARD,
      GAP
   } tx_state_t;

   // Flag field of a packet word.
   function automatic logic [2:0] word_flag(input logic [WIDTH_PKT-1:0] word);
      return word[WIDTH_PKT-1 -: 3];
   endfunction

   // Replace the flag field of a packet word, keeping reserved and data bits.
   function automatic logic [WIDTH_PKT-1:0] retag(input logic [WIDTH_PKT-1:0] word,
                                                  input logic [2:0]           flag);
      return {flag, word[WIDTH_PKT-4:0]};
   endfunction

endpackage

// File: rtl/pkt_transmit_fifo_sync.sv
// Single-clock show-ahead FIFO: q always shows the oldest entry, a read
// simply advances past it. Writes to a full FIFO and reads from an empty
// FIFO are ignored. DEPTH must be a power of two; usedw is the fill level
// modulo DEPTH.
module fifo_sync #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr,
   input  logic [WIDTH-1:0] din,
   input  logic             rd,
   output logic [WIDTH-1:0] q,
   output logic             full,
   output logic             empty,
   output logic [AW-1:0]    usedw
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             wr_ok;
   logic             rd_ok;

   assign wr_ok = wr && !full;
   assign rd_ok = rd && !empty;
   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);
   assign usedw = count[AW-1:0];
   assign q     = mem[rd_ptr];

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= din;
   end

   // Pointers and occupancy; a simultaneous write and read leaves count unchanged.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
      end
   end

endmodule

// File: rtl/pkt_transmit.sv
// Store-and-forward packet transmitter. Buffers parser words and per-packet
// forward flags, then replays complete packets to the CDP (or silently drops
// them), inserting one idle cycle after every transmitted packet.
module pkt_transmit
   import pkt_transmit_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         pkt_valid,
   input  logic [138:0] pkt,
   input  logic         metadata_valid,
   input  logic [287:0] metadata,
   output logic [7:0]   transmit_usedw,
   input  logic         cdp2um_tx_enable,
   output logic         um2cdp_data_valid,
   output logic [138:0] um2cdp_data,
   output logic [15:0]  drop_count
);

   logic [WIDTH_PKT-1:0] pkt_q;
   logic                 pkt_full;
   logic                 pkt_empty;
   logic                 pkt_rd;
   logic [7:0]           pkt_usedw;
   logic [0:0]           flag_q;
   logic                 flag_full;
   logic                 flag_empty;
   logic                 flag_rd;
   logic [3:0]           flag_usedw;
   logic [7:0]           pkt_cnt;
   tx_state_t            state;
   logic                 start;
   logic                 rd_vld;
   logic [2:0]           out_flag;
   logic                 wr_tail;
   logic                 rd_tail;
   logic                 vld_p0;
   logic [WIDTH_PKT-1:0] word_p0;
   logic                 side_unused;

   fifo_sync #(.WIDTH(WIDTH_PKT), .DEPTH(PKT_FIFO_DEPTH)) u_pkt_fifo (
      .clk   (clk),
      .reset (reset),
      .wr    (pkt_valid),
      .din   (pkt),
      .rd    (pkt_rd),
      .q     (pkt_q),
      .full  (pkt_full),
      .empty (pkt_empty),
      .usedw (pkt_usedw)
   );

   fifo_sync #(.WIDTH(1), .DEPTH(FLAG_FIFO_DEPTH)) u_flag_fifo (
      .clk   (clk),
      .reset (reset),
      .wr    (metadata_valid),
      .din   (metadata[0]),
      .rd    (flag_rd),
      .q     (flag_q),
      .full  (flag_full),
      .empty (flag_empty),
      .usedw (flag_usedw)
   );

   // Descriptor bits above the forward flag and the flag FIFO status are not needed here.
   assign side_unused = ^{flag_full, flag_usedw, metadata[287:1]};

   assign transmit_usedw = pkt_usedw;

   // A packet may leave only once its tail is stored; forwarded packets also need the CDP ready.
   assign start = (pkt_cnt != 8'd0) && !flag_empty && !pkt_empty &&
                  (!flag_q[0] || cdp2um_tx_enable);

   assign wr_tail = pkt_valid && !pkt_full && (word_flag(pkt) == FLAG_TAIL);
   assign rd_tail = pkt_rd && (word_flag(pkt_q) == FLAG_TAIL);

   // Read strobes: IDLE consumes the head with its flag, SEND/DISCARD stream the rest.
   // A head seen mid-packet closes the packet (retagged as tail) but stays queued.
   always_comb begin
      pkt_rd   = 1'b0;
      flag_rd  = 1'b0;
      rd_vld   = 1'b0;
      out_flag = word_flag(pkt_q);
      case (state)
         IDLE: begin
            if (start) begin
               pkt_rd  = 1'b1;
               flag_rd = 1'b1;
               rd_vld  = flag_q[0];
            end
         end
         SEND: begin
            if (!pkt_empty) begin
               rd_vld = 1'b1;
               if (word_flag(pkt_q) == FLAG_HEAD) out_flag = FLAG_TAIL;
               else                               pkt_rd   = 1'b1;
            end
         end
         DISCARD: begin
            if (!pkt_empty && (word_flag(pkt_q) != FLAG_HEAD)) pkt_rd = 1'b1;
         end
         default: ;
      endcase
   end

   // Count of complete packets held in the packet FIFO.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pkt_cnt <= 8'd0;
      end else if (wr_tail && !rd_tail) begin
         pkt_cnt <= pkt_cnt + 8'd1;
      end else if (rd_tail && !wr_tail) begin
         pkt_cnt <= pkt_cnt - 8'd1;
      end
   end

   // Saturating count of parser words refused by a full packet FIFO.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         drop_count <= 16'd0;
      end else if (pkt_valid && pkt_full && (drop_count != 16'hFFFF)) begin
         drop_count <= drop_count + 16'd1;
      end
   end

   // Transmit state machine.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  if (word_flag(pkt_q) == FLAG_TAIL) state <= flag_q[0] ? GAP : IDLE;
                  else                               state <= flag_q[0] ? SEND : DISCARD;
               end
            end
            SEND: begin
               if (!pkt_empty) begin
                  case (word_flag(pkt_q))
                     FLAG_HEAD, FLAG_TAIL: state <= GAP;
                     FLAG_BODY:            state <= SEND;
                     default:              state <= SEND;
                  endcase
               end
            end
            DISCARD: begin
               if (!pkt_empty && ((word_flag(pkt_q) == FLAG_HEAD) ||
                                  (word_flag(pkt_q) == FLAG_TAIL))) begin
                  state <= IDLE;
               end
            end
            GAP:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // ---- stage p0: word read from the FIFO ----
   // Valid for the read stage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) vld_p0 <= 1'b0;
      else       vld_p0 <= rd_vld;
   end

   // Captured read word with its (possibly rewritten) flag.
   always_ff @(posedge clk) begin
      if (rd_vld) word_p0 <= retag(pkt_q, out_flag);
   end

   // ---- stage p1: CDP output register ----
   // Output word holds its last value while valid is low.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         um2cdp_data_valid <= 1'b0;
         um2cdp_data       <= '0;
      end else begin
         um2cdp_data_valid <= vld_p0;
         if (vld_p0) um2cdp_data <= word_p0;
      end
   end

endmodule

// File: tb/tb_pkt_transmit.sv
// Self-checking bench for pkt_transmit: directed scenarios plus a randomized
// mix of forwarded and discarded packets against a packet-level model.
module tb_pkt_transmit;
   import pkt_transmit_pkg::*;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         pkt_valid = 1'b0;
   logic [138:0] pkt = '0;
   logic         metadata_valid = 1'b0;
   logic [287:0] metadata = '0;
   logic         cdp2um_tx_enable = 1'b0;
   logic [7:0]   transmit_usedw;
   logic         um2cdp_data_valid;
   logic [138:0] um2cdp_data;
   logic [15:0]  drop_count;

   int checks = 0;
   int failures = 0;

   logic [138:0] tx_words[$];
   logic [138:0] exp_q[$];
   bit           exp_v[$];
   bit           drv_done;

   always #5 clk = ~clk;

   pkt_transmit dut (
      .clk               (clk),
      .reset             (reset),
      .pkt_valid         (pkt_valid),
      .pkt               (pkt),
      .metadata_valid    (metadata_valid),
      .metadata          (metadata),
      .transmit_usedw    (transmit_usedw),
      .cdp2um_tx_enable  (cdp2um_tx_enable),
      .um2cdp_data_valid (um2cdp_data_valid),
      .um2cdp_data       (um2cdp_data),
      .drop_count        (drop_count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [138:0] rand_word(input logic [2:0] flag);
      logic [138:0] w;
      w = {flag, 8'($urandom), $urandom, $urandom, $urandom, $urandom};
      return w;
   endfunction

   task automatic make_packet(input int len);
      tx_words.delete();
      tx_words.push_back(rand_word(FLAG_HEAD));
      for (int i = 1; i < len - 1; i++) tx_words.push_back(rand_word(FLAG_BODY));
      tx_words.push_back(rand_word(FLAG_TAIL));
   endtask

   // Drives tx_words; metadata strobes with every head word. Returns one
   // cycle after the last word's write edge, with pkt_valid low.
   task automatic drive_packet(input bit fwd, input int idle_pct);
      for (int i = 0; i < tx_words.size(); i++) begin
         int n = 0;
         while (n < 3 && $urandom_range(0, 99) < idle_pct) begin
            pkt_valid = 1'b0;
            metadata_valid = 1'b0;
            tick();
            n++;
         end
         pkt_valid = 1'b1;
         pkt = tx_words[i];
         metadata_valid = (tx_words[i][138:136] == FLAG_HEAD);
         for (int k = 0; k < 9; k++) metadata[k*32 +: 32] = $urandom;
         metadata[0] = fwd;
         tick();
      end
      pkt_valid = 1'b0;
      metadata_valid = 1'b0;
   endtask

   task automatic do_reset();
      pkt_valid = 1'b0;
      metadata_valid = 1'b0;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (um2cdp_data_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b expected 0", um2cdp_data_valid); end
      checks++; if (um2cdp_data !== '0) begin failures++; $display("FAIL reset_data got %h expected 0", um2cdp_data); end
      checks++; if (transmit_usedw !== 8'd0) begin failures++; $display("FAIL reset_usedw got %0d expected 0", transmit_usedw); end
      checks++; if (drop_count !== 16'd0) begin failures++; $display("FAIL reset_drop got %0d expected 0", drop_count); end
   endtask

   task automatic test_single_forward();
      logic [138:0] w[4];
      logic [2:0]   fl[4];
      bit           ev;
      fl = '{FLAG_HEAD, FLAG_BODY, FLAG_BODY, FLAG_TAIL};
      cdp2um_tx_enable = 1'b1;
      make_packet(4);
      for (int i = 0; i < 4; i++) w[i] = tx_words[i];
      drive_packet(1'b1, 0);
      for (int c = 1; c <= 7; c++) begin
         tick();
         ev = (c >= 2 && c <= 5);
         checks++;
         if (um2cdp_data_valid !== ev) begin failures++; $display("FAIL single_valid c=%0d got %b expected %b", c, um2cdp_data_valid, ev); end
         if (ev) begin
            checks++;
            if (um2cdp_data !== w[c-2]) begin failures++; $display("FAIL single_data c=%0d got %h expected %h", c, um2cdp_data, w[c-2]); end
            checks++;
            if (um2cdp_data[138:136] !== fl[c-2]) begin failures++; $display("FAIL single_flag c=%0d got %b expected %b", c, um2cdp_data[138:136], fl[c-2]); end
         end
         if (c == 6) begin
            checks++;
            if (um2cdp_data !== w[3]) begin failures++; $display("FAIL single_hold got %h expected %h", um2cdp_data, w[3]); end
         end
      end
      checks++; if (transmit_usedw !== 8'd0) begin failures++; $display("FAIL single_usedw got %0d expected 0", transmit_usedw); end
   endtask

   task automatic test_discard();
      logic [138:0] last;
      int           eu;
      last = um2cdp_data;
      cdp2um_tx_enable = 1'($urandom_range(0, 1));
      make_packet(4);
      drive_packet(1'b0, 0);
      checks++; if (transmit_usedw !== 8'd4) begin failures++; $display("FAIL discard_usedw_full got %0d expected 4", transmit_usedw); end
      for (int c = 1; c <= 6; c++) begin
         tick();
         eu = (c < 4) ? 4 - c : 0;
         checks++; if (um2cdp_data_valid !== 1'b0) begin failures++; $display("FAIL discard_valid c=%0d got %b expected 0", c, um2cdp_data_valid); end
         checks++; if (um2cdp_data !== last) begin failures++; $display("FAIL discard_hold c=%0d got %h expected %h", c, um2cdp_data, last); end
         checks++; if (transmit_usedw !== 8'(eu)) begin failures++; $display("FAIL discard_usedw c=%0d got %0d expected %0d", c, transmit_usedw, eu); end
      end
   endtask

   task automatic test_back_to_back();
      int           total = 0;
      int           seen = 0;
      logic [138:0] ew;
      cdp2um_tx_enable = 1'b0;
      exp_q.delete();
      exp_v.delete();
      exp_v.push_back(1'b0);
      for (int p = 0; p < 3; p++) begin
         make_packet($urandom_range(2, 6));
         foreach (tx_words[k]) begin exp_q.push_back(tx_words[k]); exp_v.push_back(1'b1); end
         exp_v.push_back(1'b0);
         total += tx_words.size();
         drive_packet(1'b1, 0);
      end
      repeat (10) begin
         tick();
         if (um2cdp_data_valid) seen++;
      end
      checks++; if (seen !== 0) begin failures++; $display("FAIL b2b_held got %0d valid cycles expected 0", seen); end
      checks++; if (transmit_usedw !== 8'(total)) begin failures++; $display("FAIL b2b_usedw got %0d expected %0d", transmit_usedw, total); end
      cdp2um_tx_enable = 1'b1;
      foreach (exp_v[c]) begin
         tick();
         checks++;
         if (um2cdp_data_valid !== exp_v[c]) begin failures++; $display("FAIL b2b_valid c=%0d got %b expected %b", c, um2cdp_data_valid, exp_v[c]); end
         if (exp_v[c]) begin
            ew = exp_q.pop_front();
            checks++;
            if (um2cdp_data !== ew) begin failures++; $display("FAIL b2b_data c=%0d got %h expected %h", c, um2cdp_data, ew); end
         end
      end
      checks++; if (transmit_usedw !== 8'd0) begin failures++; $display("FAIL b2b_drained got %0d expected 0", transmit_usedw); end
   endtask

   task automatic test_random();
      logic [138:0] all_words[$];
      int           lens[8];
      bit           fwds[8];
      logic [138:0] ew;
      bit           prev_tail = 1'b0;
      exp_q.delete();
      for (int p = 0; p < 8; p++) begin
         lens[p] = $urandom_range(2, 6);
         fwds[p] = (p == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         make_packet(lens[p]);
         foreach (tx_words[k]) begin
            all_words.push_back(tx_words[k]);
            if (fwds[p]) exp_q.push_back(tx_words[k]);
         end
      end
      drv_done = 1'b0;
      fork
         begin
            int idx = 0;
            for (int p = 0; p < 8; p++) begin
               tx_words.delete();
               for (int k = 0; k < lens[p]; k++) begin tx_words.push_back(all_words[idx]); idx++; end
               drive_packet(fwds[p], 30);
            end
            drv_done = 1'b1;
         end
         begin
            while (!drv_done) begin
               cdp2um_tx_enable = 1'($urandom_range(0, 1));
               tick();
            end
            cdp2um_tx_enable = 1'b1;
         end
         begin
            for (int c = 0; c < 800; c++) begin
               tick();
               if (prev_tail) begin
                  checks++;
                  if (um2cdp_data_valid !== 1'b0) begin failures++; $display("FAIL rand_gap c=%0d got %b expected 0", c, um2cdp_data_valid); end
               end
               prev_tail = 1'b0;
               if (um2cdp_data_valid) begin
                  checks++;
                  if (exp_q.size() == 0) begin
                     failures++; $display("FAIL rand_extra got %h expected no word", um2cdp_data);
                  end else begin
                     ew = exp_q.pop_front();
                     if (um2cdp_data !== ew) begin failures++; $display("FAIL rand_data c=%0d got %h expected %h", c, um2cdp_data, ew); end
                  end
                  prev_tail = (um2cdp_data[138:136] == FLAG_TAIL);
               end
               if (drv_done && exp_q.size() == 0) break;
            end
         end
      join
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rand_timeout got %0d words left expected 0", exp_q.size()); end
      repeat (12) tick();
      checks++; if (transmit_usedw !== 8'd0) begin failures++; $display("FAIL rand_usedw got %0d expected 0", transmit_usedw); end
   endtask

   task automatic test_missing_tail();
      logic [138:0] a[3];
      logic [138:0] b[3];
      logic [138:0] ew[$];
      bit           ev[10];
      logic [138:0] e;
      cdp2um_tx_enable = 1'b1;
      a[0] = rand_word(FLAG_HEAD);
      a[1] = rand_word(FLAG_BODY);
      a[2] = rand_word(FLAG_BODY);
      make_packet(3);
      for (int i = 0; i < 3; i++) b[i] = tx_words[i];
      tx_words.delete();
      for (int i = 0; i < 3; i++) tx_words.push_back(a[i]);
      for (int i = 0; i < 3; i++) tx_words.push_back(b[i]);
      ev = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 0};
      ew = '{a[0], a[1], a[2], {FLAG_TAIL, b[0][135:0]}, b[0], b[1], b[2]};
      drive_packet(1'b1, 0);
      for (int c = 0; c < 10; c++) begin
         tick();
         checks++;
         if (um2cdp_data_valid !== ev[c]) begin failures++; $display("FAIL trunc_valid c=%0d got %b expected %b", c + 1, um2cdp_data_valid, ev[c]); end
         if (ev[c]) begin
            e = ew.pop_front();
            checks++;
            if (um2cdp_data !== e) begin failures++; $display("FAIL trunc_data c=%0d got %h expected %h", c + 1, um2cdp_data, e); end
         end
      end
      checks++; if (transmit_usedw !== 8'd0) begin failures++; $display("FAIL trunc_usedw got %0d expected 0", transmit_usedw); end
   endtask

   task automatic test_overflow();
      int eu;
      int ed;
      do_reset();
      cdp2um_tx_enable = 1'b0;
      for (int i = 1; i <= 260; i++) begin
         pkt_valid = 1'b1;
         pkt = rand_word((i == 1) ? FLAG_HEAD : FLAG_BODY);
         metadata_valid = (i == 1);
         metadata = '0;
         tick();
         eu = ((i < 256) ? i : 256) % 256;
         ed = (i > 256) ? i - 256 : 0;
         checks++; if (transmit_usedw !== 8'(eu)) begin failures++; $display("FAIL ovf_usedw i=%0d got %0d expected %0d", i, transmit_usedw, eu); end
         checks++; if (drop_count !== 16'(ed)) begin failures++; $display("FAIL ovf_drop i=%0d got %0d expected %0d", i, drop_count, ed); end
      end
      pkt_valid = 1'b0;
      metadata_valid = 1'b0;
      repeat (3) tick();
      checks++; if (um2cdp_data_valid !== 1'b0) begin failures++; $display("FAIL ovf_valid got %b expected 0", um2cdp_data_valid); end
      #2;
      reset = 1'b1;
      #1;
      checks++; if (drop_count !== 16'd0) begin failures++; $display("FAIL ovf_reset_drop got %0d expected 0", drop_count); end
      checks++; if (transmit_usedw !== 8'd0) begin failures++; $display("FAIL ovf_reset_usedw got %0d expected 0", transmit_usedw); end
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [138:0] w[4];
      bit           ev;
      cdp2um_tx_enable = 1'b1;
      make_packet(4);
      for (int i = 0; i < 4; i++) w[i] = tx_words[i];
      drive_packet(1'b1, 0);
      repeat (3) tick();
      checks++; if (um2cdp_data !== w[1]) begin failures++; $display("FAIL mid_second_word got %h expected %h", um2cdp_data, w[1]); end
      reset = 1'b1;
      #1;
      checks++; if (um2cdp_data_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got %b expected 0", um2cdp_data_valid); end
      checks++; if (um2cdp_data !== '0) begin failures++; $display("FAIL mid_data got %h expected 0", um2cdp_data); end
      checks++; if (transmit_usedw !== 8'd0) begin failures++; $display("FAIL mid_usedw got %0d expected 0", transmit_usedw); end
      checks++; if (drop_count !== 16'd0) begin failures++; $display("FAIL mid_drop got %0d expected 0", drop_count); end
      tick();
      tick();
      reset = 1'b0;
      make_packet(4);
      for (int i = 0; i < 4; i++) w[i] = tx_words[i];
      drive_packet(1'b1, 0);
      for (int c = 1; c <= 7; c++) begin
         tick();
         ev = (c >= 2 && c <= 5);
         checks++;
         if (um2cdp_data_valid !== ev) begin failures++; $display("FAIL post_valid c=%0d got %b expected %b", c, um2cdp_data_valid, ev); end
         if (ev) begin
            checks++;
            if (um2cdp_data !== w[c-2]) begin failures++; $display("FAIL post_data c=%0d got %h expected %h", c, um2cdp_data, w[c-2]); end
         end
      end
      checks++; if (transmit_usedw !== 8'd0) begin failures++; $display("FAIL post_usedw got %0d expected 0", transmit_usedw); end
   endtask

   initial begin
      test_reset();
      test_single_forward();
      test_discard();
      test_back_to_back();
      test_random();
      test_missing_tail();
      test_overflow();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
